// File: rtl/unidad_deteccion_riesgos.sv
// Hazard detection and stall controller for the 5-stage core.
// Resolves load-use hazards, variable-latency MEM accesses and taken-branch
// flushes; counts stall cycles and flags memory waits that never finish.
module unidad_deteccion_riesgos #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter bit          ZERO_REG   = 1'b1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] reg1_ID,
  input  logic [REG_ADDR_W-1:0] reg2_ID,
  input  logic [REG_ADDR_W-1:0] ST_src_ID,
  input  logic                  reg1_use_ID,
  input  logic                  reg2_use_ID,
  input  logic                  ST_use_ID,
  input  logic [REG_ADDR_W-1:0] dest_EXE,
  input  logic                  MEM_R_EN_EXE,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ready,
  input  logic                  branch_taken_EXE,
  input  logic                  stats_clr,
  output logic                  stall_PC,
  output logic                  stall_IF_ID,
  output logic                  bubble_ID_EXE,
  output logic                  freeze_back,
  output logic                  flush_IF_ID,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;

  logic match_reg1;
  logic match_reg2;
  logic match_st;
  logic load_use;
  logic mem_stall;

  // Operand comparison against the load destination in EXE
  always_comb begin
    match_reg1 = reg1_use_ID && (reg1_ID == dest_EXE) &&
                 !(ZERO_REG && (reg1_ID == '0));
    match_reg2 = reg2_use_ID && (reg2_ID == dest_EXE) &&
                 !(ZERO_REG && (reg2_ID == '0));
    match_st   = ST_use_ID && (ST_src_ID == dest_EXE) &&
                 !(ZERO_REG && (ST_src_ID == '0));
    load_use   = MEM_R_EN_EXE && (match_reg1 || match_reg2 || match_st);
    mem_stall  = ((state == RUN) && mem_req_MEM && !mem_ready) ||
                 ((state == MEM_WAIT) && !mem_ready);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and prioritised pipeline controls
  always_comb begin
    state_next    = state;
    stall_PC      = 1'b0;
    stall_IF_ID   = 1'b0;
    bubble_ID_EXE = 1'b0;
    freeze_back   = 1'b0;
    flush_IF_ID   = 1'b0;

    case (state)
      RUN:      if (mem_req_MEM && !mem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_next = RUN;
      default:  state_next = RUN;
    endcase

    // Controls are forced low while reset is held, even with live inputs.
    if (rst_n) begin
      if (mem_stall) begin
        // Branch and load-use are held back; frozen stages re-present them.
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        freeze_back = 1'b1;
      end else if (branch_taken_EXE) begin
        // Decode instruction is squashed, so any load-use is irrelevant.
        flush_IF_ID   = 1'b1;
        bubble_ID_EXE = 1'b1;
      end else if (load_use) begin
        stall_PC      = 1'b1;
        stall_IF_ID   = 1'b1;
        bubble_ID_EXE = 1'b1;
      end
    end
  end

  // Wait counter next value: counts MEM_WAIT cycles, saturating, zero in RUN
  always_comb begin
    wait_cnt_next = '0;
    if ((state == MEM_WAIT) && (state_next == MEM_WAIT)) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt_next = wait_cnt + 1'b1;
      end else begin
        wait_cnt_next = wait_cnt;
      end
    end
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (wait_cnt_next == WAIT_MAX) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Saturating stall-cycle counter with synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stats_clr) begin
      stall_count <= '0;
    end else if (stall_PC && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_unidad_deteccion_riesgos.sv
// Self-checking bench for unidad_deteccion_riesgos: table of single-cycle
// hazard vectors plus hand-written memory-wait, branch, timeout and reset runs.
module tb_unidad_deteccion_riesgos;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] reg1_ID, reg2_ID, ST_src_ID, dest_EXE;
  logic          reg1_use_ID, reg2_use_ID, ST_use_ID;
  logic          MEM_R_EN_EXE, mem_req_MEM, mem_ready, branch_taken_EXE;
  logic          stats_clr;
  logic          stall_PC, stall_IF_ID, bubble_ID_EXE, freeze_back, flush_IF_ID;
  logic [CW-1:0] stall_count;
  logic          mem_timeout;

  unidad_deteccion_riesgos #(
    .REG_ADDR_W(AW),
    .ZERO_REG  (1'b1),
    .CNT_W     (CW),
    .TIMEOUT   (64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reg1_ID         (reg1_ID),
    .reg2_ID         (reg2_ID),
    .ST_src_ID       (ST_src_ID),
    .reg1_use_ID     (reg1_use_ID),
    .reg2_use_ID     (reg2_use_ID),
    .ST_use_ID       (ST_use_ID),
    .dest_EXE        (dest_EXE),
    .MEM_R_EN_EXE    (MEM_R_EN_EXE),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ready       (mem_ready),
    .branch_taken_EXE(branch_taken_EXE),
    .stats_clr       (stats_clr),
    .stall_PC        (stall_PC),
    .stall_IF_ID     (stall_IF_ID),
    .bubble_ID_EXE   (bubble_ID_EXE),
    .freeze_back     (freeze_back),
    .flush_IF_ID     (flush_IF_ID),
    .stall_count     (stall_count),
    .mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bit order: {stall_PC, stall_IF_ID, bubble_ID_EXE, freeze_back, flush_IF_ID}
  typedef struct {
    logic [AW-1:0] r1, r2, st;
    logic          u1, u2, us;
    logic [AW-1:0] dest;
    logic          ld, req, rdy, br;
    logic [4:0]    exp;
  } vec_t;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11100;
  localparam logic [4:0] C_MEM  = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00101;

  vec_t          tbl[11];
  vec_t          idle;
  vec_t          v;
  logic [4:0]    exp_q[$];
  logic [CW-1:0] m_cnt;
  int unsigned   errors;
  int unsigned   checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x, input logic clr);
    reg1_ID          = x.r1;
    reg2_ID          = x.r2;
    ST_src_ID        = x.st;
    reg1_use_ID      = x.u1;
    reg2_use_ID      = x.u2;
    ST_use_ID        = x.us;
    dest_EXE         = x.dest;
    MEM_R_EN_EXE     = x.ld;
    mem_req_MEM      = x.req;
    mem_ready        = x.rdy;
    branch_taken_EXE = x.br;
    stats_clr        = clr;
  endtask

  // One clock cycle: drive after posedge, score the outputs at the negedge
  task automatic step(input vec_t x, input logic clr, input string name);
    logic [4:0] e;
    @(posedge clk);
    #1;
    drive(x, clr);
    exp_q.push_back(x.exp);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {stall_PC, stall_IF_ID, bubble_ID_EXE, freeze_back, flush_IF_ID}, e);
      check({name, "_cnt"}, stall_count, m_cnt);
      if (clr) m_cnt = '0;
      else if (e[4] && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_cnt  = '0;

    //            r1     r2     st     u1 u2 us dest   ld req rdy br exp
    idle    = '{4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 0, C_NONE};
    tbl[0]  = '{4'd1, 4'd3, 4'd2, 1, 1, 0, 4'd3, 1, 0, 0, 0, C_LU};
    tbl[1]  = '{4'd1, 4'd3, 4'd2, 1, 0, 0, 4'd3, 1, 0, 0, 0, C_NONE};
    tbl[2]  = '{4'd0, 4'd5, 4'd6, 1, 1, 1, 4'd0, 1, 0, 0, 0, C_NONE};
    tbl[3]  = '{4'd1, 4'd2, 4'd7, 1, 1, 1, 4'd7, 1, 0, 0, 0, C_LU};
    tbl[4]  = '{4'd5, 4'd2, 4'd3, 1, 1, 1, 4'd5, 0, 0, 0, 0, C_NONE};
    tbl[5]  = '{4'd1, 4'd3, 4'd2, 1, 1, 0, 4'd3, 1, 0, 0, 1, C_BR};
    tbl[6]  = '{4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, 1, C_BR};
    tbl[7]  = '{4'd1, 4'd3, 4'd2, 1, 1, 0, 4'd3, 1, 1, 1, 0, C_LU};
    tbl[8]  = '{4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1, 0, C_NONE};
    tbl[9]  = '{4'd5, 4'd4, 4'd9, 1, 0, 0, 4'd5, 1, 0, 0, 0, C_LU};
    tbl[10] = '{4'd15, 4'd4, 4'd9, 1, 0, 1, 4'd9, 1, 0, 0, 0, C_LU};

    // Reset with a stalling input pattern: everything must read zero
    rst_n = 1'b0;
    v = tbl[0];
    v.req = 1'b1;
    drive(v, 1'b0);
    #3;
    check("reset_ctl", {stall_PC, stall_IF_ID, bubble_ID_EXE, freeze_back, flush_IF_ID}, 5'b0);
    check("reset_cnt", stall_count, '0);
    check("reset_timeout", mem_timeout, 1'b0);
    drive(idle, 1'b0);
    #9;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end
    step(idle, 1'b0, "idle0");

    // Memory wait of three cycles with a pending load-use underneath
    v = tbl[0];
    v.req = 1'b1;
    v.rdy = 1'b0;
    v.exp = C_MEM;
    for (int i = 0; i < 3; i++) step(v, 1'b0, $sformatf("memwait%0d", i));
    v.rdy = 1'b1;
    v.exp = C_LU;
    step(v, 1'b0, "mem_ready_lu");
    step(idle, 1'b0, "after_mem");

    // Branch arriving during a memory wait is deferred to the ready cycle
    v = idle;
    v.req = 1'b1;
    v.br  = 1'b1;
    v.exp = C_MEM;
    step(v, 1'b0, "br_wait0");
    v.req = 1'b0;
    step(v, 1'b0, "br_wait1");
    v.rdy = 1'b1;
    v.exp = C_BR;
    step(v, 1'b0, "br_release");
    step(idle, 1'b0, "after_br");

    // Synchronous clear wins over a simultaneous stall increment
    step(tbl[0], 1'b1, "clr_lu");
    step(idle, 1'b0, "after_clr");

    // Long wait: timeout flag rises and stays; stall_count saturates
    v = idle;
    v.req = 1'b1;
    v.exp = C_MEM;
    for (int k = 1; k <= 70; k++) begin
      step(v, 1'b0, $sformatf("long%0d", k));
      if (k == 60) check("timeout_early", mem_timeout, 1'b0);
      if (k >= 67) check($sformatf("timeout_set%0d", k), mem_timeout, 1'b1);
    end

    // Asynchronous reset in the middle of the wait
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_ctl", {stall_PC, stall_IF_ID, bubble_ID_EXE, freeze_back, flush_IF_ID}, 5'b0);
    check("midreset_timeout", mem_timeout, 1'b0);
    check("midreset_cnt", stall_count, '0);
    drive(idle, 1'b0);
    m_cnt = '0;
    #1;
    rst_n = 1'b1;
    step(idle, 1'b0, "post_reset_idle");
    step(tbl[0], 1'b0, "post_reset_lu");
    check("post_reset_timeout", mem_timeout, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
